// File: rtl/bcd_disp_pkg.sv
// Shared types and segment encodings for the multiplexed 3-digit BCD display.
// Segment order is {g,f,e,d,c,b,a}, active low (common-anode).
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd3_t;

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show a dash.
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (nibble <= 4'd9) begin
            seg = SEG_DIGIT[nibble];
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 3-digit common-anode 7-segment driver with frame-synchronous
// value updates, optional leading-zero blanking and a valid/ready input.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    digit_t           idx, idx_next;
    bcd3_t            disp, pend;
    logic             pending;

    logic       tc, boundary, accept;
    logic [3:0] nibble;
    logic       blank;
    logic [2:0] an_next;
    logic [6:0] seg_next;

    assign in_ready = ~pending;
    assign tc       = (div_cnt == CNT_W'(DIV - 1));
    assign boundary = tc && (idx == DIG_HUNDREDS);
    assign accept   = in_valid && !pending;

    always_comb begin
        idx_next = DIG_UNITS;
        nibble   = disp.units;
        blank    = 1'b0;
        an_next  = 3'b110;
        case (idx)
            DIG_UNITS: begin
                idx_next = DIG_TENS;
            end
            DIG_TENS: begin
                idx_next = DIG_HUNDREDS;
                nibble   = disp.tens;
                blank    = lz_en && (disp.hundreds == 4'd0) && (disp.tens == 4'd0);
                an_next  = 3'b101;
            end
            DIG_HUNDREDS: begin
                idx_next = DIG_UNITS;
                nibble   = disp.hundreds;
                blank    = lz_en && (disp.hundreds == 4'd0);
                an_next  = 3'b011;
            end
            default: ;
        endcase
    end

    bcd_seg_decode u_decode (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg_next)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            div_cnt <= '0;
            idx     <= DIG_UNITS;
            disp    <= '0;
            pend    <= '0;
            pending <= 1'b0;
            seg     <= SEG_BLANK;
            an      <= 3'b111;
            frame_o <= 1'b0;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + CNT_W'(1);
            if (tc) begin
                idx <= idx_next;
            end
            // A value accepted on the boundary cycle only stages; it never bypasses to disp.
            if (boundary && pending) begin
                disp    <= pend;
                pending <= 1'b0;
            end else if (accept) begin
                pend    <= bcd_in;
                pending <= 1'b1;
            end
            seg     <= seg_next;
            an      <= an_next;
            frame_o <= boundary;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with DIV = 2 (6-cycle frames).
module tb_bcd_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_in = '0;
    logic        in_valid = 1'b0;
    logic        lz_en = 1'b0;
    logic        in_ready;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_o;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_display_scan #(.DIV(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .lz_en    (lz_en),
        .seg      (seg),
        .an       (an),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] bcd;
        logic        lz;
        logic [6:0]  u;
        logic [6:0]  t;
        logic [6:0]  h;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples one frame starting just after a boundary edge; optionally drops
    // in_valid after the first edge and reports in_ready at that point.
    task automatic capture(input bit release_valid, output logic [6:0] u,
                           output logic [6:0] t, output logic [6:0] h, output logic rdy1);
        int nu = 0, nt = 0, nh = 0;
        u = 7'hxx; t = 7'hxx; h = 7'hxx; rdy1 = 1'bx;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                rdy1 = in_ready;
                if (release_valid) in_valid = 1'b0;
            end
            case (an)
                3'b110: begin u = seg; nu++; end
                3'b101: begin t = seg; nt++; end
                3'b011: begin h = seg; nh++; end
                default: check("an_one_hot", {29'd0, an}, 32'h6);
            endcase
        end
        check("lit_cycles_units", nu, 2);
        check("lit_cycles_tens", nt, 2);
        check("lit_cycles_hundreds", nh, 2);
    endtask

    task automatic send(input logic [11:0] v);
        bit done = 1'b0;
        bcd_in   = v;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("send_accepted", {31'd0, done}, 1);
    endtask

    task automatic wait_apply();
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("apply_ready", {31'd0, in_ready}, 1);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 20 && !frame_o; i++) tick();
        check("frame_seen", {31'd0, frame_o}, 1);
    endtask

    logic [6:0] u, t, h;
    logic       r1;
    logic [2:0] exp_an    [7] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
    logic       exp_frame [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        vec[0] = '{12'h123, 1'b0, 7'h30, 7'h24, 7'h79};
        vec[1] = '{12'h007, 1'b1, 7'h78, 7'h7F, 7'h7F};
        vec[2] = '{12'h000, 1'b1, 7'h40, 7'h7F, 7'h7F};
        vec[3] = '{12'h000, 1'b0, 7'h40, 7'h40, 7'h40};
        vec[4] = '{12'h050, 1'b1, 7'h40, 7'h12, 7'h7F};
        vec[5] = '{12'h908, 1'b1, 7'h00, 7'h40, 7'h10};
        vec[6] = '{12'hFB9, 1'b0, 7'h10, 7'h3F, 7'h3F};
        vec[7] = '{12'h456, 1'b0, 7'h02, 7'h12, 7'h19};
        vec[8] = '{12'h200, 1'b1, 7'h40, 7'h40, 7'h24};

        // Reset held for three cycles, then the scan sequence from release.
        repeat (3) tick();
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_an", {29'd0, an}, 32'h7);
        check("rst_ready", {31'd0, in_ready}, 1);
        check("rst_frame", {31'd0, frame_o}, 0);
        rst = 1'b0;
        check("rel_first_an", {29'd0, an}, 32'h7);
        check("rel_first_seg", {25'd0, seg}, 32'h7F);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("scan_an_%0d", i), {29'd0, an}, {29'd0, exp_an[i]});
            check($sformatf("scan_frame_%0d", i), {31'd0, frame_o}, {31'd0, exp_frame[i]});
        end

        // Table-driven value loads.
        foreach (vec[i]) begin
            lz_en = vec[i].lz;
            send(vec[i].bcd);
            check($sformatf("v%0d_ready_low", i), {31'd0, in_ready}, 0);
            wait_apply();
            capture(1'b0, u, t, h, r1);
            check($sformatf("v%0d_units", i), {25'd0, u}, {25'd0, vec[i].u});
            check($sformatf("v%0d_tens", i), {25'd0, t}, {25'd0, vec[i].t});
            check($sformatf("v%0d_hundreds", i), {25'd0, h}, {25'd0, vec[i].h});
        end

        // Back-to-back offers with in_valid held high.
        lz_en    = 1'b0;
        bcd_in   = 12'h111;
        in_valid = 1'b1;
        begin
            bit acc = 1'b0;
            for (int i = 0; i < 20 && !acc; i++) begin
                acc = in_ready;
                tick();
            end
            check("b2b_first_accept", {31'd0, acc}, 1);
        end
        check("b2b_ready_drop", {31'd0, in_ready}, 0);
        bcd_in = 12'h222;
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("b2b_ready_at_frame", {31'd0, frame_o}, 1);
        capture(1'b1, u, t, h, r1);
        check("b2b_222_accepted", {31'd0, r1}, 0);
        check("b2b_111_units", {25'd0, u}, 32'h79);
        check("b2b_111_tens", {25'd0, t}, 32'h79);
        check("b2b_111_hundreds", {25'd0, h}, 32'h79);
        check("b2b_222_applied", {31'd0, in_ready}, 1);
        capture(1'b0, u, t, h, r1);
        check("b2b_222_units", {25'd0, u}, 32'h24);
        check("b2b_222_hundreds", {25'd0, h}, 32'h24);

        // Offer coincident with the frame-boundary cycle: staged, shown a frame later.
        wait_frame();
        repeat (5) tick();
        bcd_in   = 12'hA05;
        in_valid = 1'b1;
        check("a05_ready_before", {31'd0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        check("a05_at_boundary", {31'd0, frame_o}, 1);
        check("a05_staged", {31'd0, in_ready}, 0);
        capture(1'b0, u, t, h, r1);
        check("a05_old_units", {25'd0, u}, 32'h24);
        check("a05_old_hundreds", {25'd0, h}, 32'h24);
        check("a05_applied", {31'd0, in_ready}, 1);
        capture(1'b0, u, t, h, r1);
        check("a05_units", {25'd0, u}, 32'h12);
        check("a05_tens", {25'd0, t}, 32'h40);
        check("a05_hundreds_dash", {25'd0, h}, 32'h3F);

        // Reset mid-frame with a value staged: it must be lost.
        send(12'h789);
        check("mid_pending", {31'd0, in_ready}, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_seg", {25'd0, seg}, 32'h7F);
        check("mid_rst_an", {29'd0, an}, 32'h7);
        check("mid_rst_frame", {31'd0, frame_o}, 0);
        check("mid_rst_ready", {31'd0, in_ready}, 1);
        rst = 1'b0;
        capture(1'b0, u, t, h, r1);
        check("mid_units", {25'd0, u}, 32'h40);
        check("mid_tens", {25'd0, t}, 32'h40);
        check("mid_hundreds", {25'd0, h}, 32'h40);
        capture(1'b0, u, t, h, r1);
        check("mid_lost_units", {25'd0, u}, 32'h40);
        check("mid_lost_ready", {31'd0, in_ready}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
